// File: rtl/netlist_bist_pkg.sv
// Shared types and defaults for the netlist BIST sequencer.
//   bist_state_e   : sequencer FSM states
//   DEF_*          : default LFSR seed / feedback masks for the 14-in / 8-out netlist class
//   next_galois()  : one Galois shift step for registers up to 32 bits wide
package netlist_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StDone
  } bist_state_e;

  localparam logic [13:0] DEF_LFSR_SEED = 14'h0001;
  localparam logic [13:0] DEF_LFSR_POLY = 14'h2B01;
  localparam logic [7:0]  DEF_MISR_POLY = 8'h1D;

  // Shift left by one and fold the outgoing MSB back in through poly.
  // Bits at and above 'width' are forced to zero so callers can truncate freely.
  function automatic logic [31:0] next_galois(input logic [31:0] val,
                                              input logic [31:0] poly,
                                              input int unsigned width);
    logic [31:0] mask;
    logic [31:0] shifted;
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    shifted = (val << 1) & mask;
    if (val[width-1]) begin
      shifted = shifted ^ (poly & mask);
    end
    return shifted;
  endfunction

endpackage

// File: rtl/galois_shreg.sv
// Galois shift register used both as pattern LFSR (din tied to 0) and as response MISR.
//   clk, rst  : clock, asynchronous active-high reset (register returns to RST_VAL)
//   load      : parallel load of load_val (takes priority over shift)
//   load_val  : value loaded on load
//   shift     : advance one Galois step and XOR in din
//   din       : parallel data compacted on each shift
//   q         : register contents
// W must lie in 2..32 because the step function works on a 32-bit container.
module galois_shreg
  import netlist_bist_pkg::*;
#(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   POLY    = '0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_step;

  always_comb begin
    q_step = W'(next_galois(32'(q), 32'(POLY), W)) ^ din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= q_step;
    end
  end

endmodule

// File: rtl/netlist_bist_ctrl.sv
// BIST sequencer for a combinational netlist: drives LFSR patterns onto the netlist
// inputs, waits SETTLE_CYC cycles per pattern, compacts each response into a MISR
// and compares the final signature with a golden value.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a run (honoured only in idle; wins over abort there)
//   abort     : cancel a run in progress (settle/capture only)
//   golden    : expected final signature, sampled in the done state
//   dut_in    : current pattern (LFSR register) to the netlist inputs
//   dut_out   : netlist outputs, sampled in the capture state
//   busy      : high while a run is settling/capturing
//   done      : one-cycle pulse at the end of a completed run
//   pass      : result of the last completed run, cleared by start/abort
//   signature : current MISR contents
module netlist_bist_ctrl
  import netlist_bist_pkg::*;
#(
  parameter int unsigned       IN_W         = 14,
  parameter int unsigned       OUT_W        = 8,
  parameter int unsigned       NUM_PATTERNS = 256,
  parameter int unsigned       SETTLE_CYC   = 2,
  parameter logic [IN_W-1:0]   LFSR_SEED    = IN_W'(DEF_LFSR_SEED),
  parameter logic [IN_W-1:0]   LFSR_POLY    = IN_W'(DEF_LFSR_POLY),
  parameter logic [OUT_W-1:0]  MISR_POLY    = OUT_W'(DEF_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  localparam int unsigned      CNT_W       = 16;
  localparam logic [CNT_W-1:0] LAST_PAT    = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYC - 1);

  bist_state_e      state;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] settle_cnt;
  logic [IN_W-1:0]  lfsr;
  logic [OUT_W-1:0] misr;
  logic             run_load;
  logic             run_shift;

  // Both registers reload together on an accepted start; an abort in capture
  // suppresses the shift so the registers freeze where they were.
  assign run_load  = (state == StIdle) && start;
  assign run_shift = (state == StCapture) && !abort;

  galois_shreg #(
    .W       (IN_W),
    .POLY    (LFSR_POLY),
    .RST_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .load_val (LFSR_SEED),
    .shift    (run_shift),
    .din      ({IN_W{1'b0}}),
    .q        (lfsr)
  );

  galois_shreg #(
    .W       (OUT_W),
    .POLY    (MISR_POLY),
    .RST_VAL ({OUT_W{1'b0}})
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .load_val ({OUT_W{1'b0}}),
    .shift    (run_shift),
    .din      (dut_out),
    .q        (misr)
  );

  assign dut_in    = lfsr;
  assign signature = misr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      pat_cnt    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            pat_cnt    <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= StSettle;
          end
        end
        StSettle: begin
          if (abort) begin
            settle_cnt <= '0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            state      <= StIdle;
          end else if (settle_cnt == LAST_SETTLE) begin
            settle_cnt <= '0;
            state      <= StCapture;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        StCapture: begin
          if (abort) begin
            pass  <= 1'b0;
            busy  <= 1'b0;
            state <= StIdle;
          end else if (pat_cnt == LAST_PAT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else begin
            pat_cnt <= pat_cnt + 1'b1;
            state   <= StSettle;
          end
        end
        StDone: begin
          pass  <= (misr == golden);
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // A zero seed locks the LFSR at zero; with a valid seed zero is unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_seed_nonzero: assert (LFSR_SEED != '0);
      a_lfsr_nonzero: assert (lfsr != '0);
    end
  end

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Self-checking bench for netlist_bist_ctrl: a short 4-pattern instance driven by a
// behavioural netlist model, and a full-period instance with a maximal LFSR polynomial.
module tb_netlist_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  golden = 8'h00;
  logic [13:0] dut_in;
  logic [7:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  signature;

  logic        l_start = 1'b0;
  logic        l_abort = 1'b0;
  logic [7:0]  l_golden = 8'h00;
  logic [13:0] l_dut_in;
  logic [7:0]  l_dut_out;
  logic        l_busy;
  logic        l_done;
  logic        l_pass;
  logic [7:0]  l_sig;

  int checks = 0;
  int failures = 0;
  int mode = 0;

  always #5 clk = ~clk;

  // Netlist model: 0 = outputs tied low, 1 = identity slice, 2 = inverted slice.
  always_comb begin
    dut_out = 8'h00;
    case (mode)
      1:       dut_out = dut_in[7:0];
      2:       dut_out = ~dut_in[7:0];
      default: dut_out = 8'h00;
    endcase
  end
  assign l_dut_out = 8'h00;

  netlist_bist_ctrl #(
    .NUM_PATTERNS (4),
    .SETTLE_CYC   (2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .golden    (golden),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  netlist_bist_ctrl #(
    .NUM_PATTERNS (16383),
    .SETTLE_CYC   (2),
    .LFSR_POLY    (14'h002B)
  ) u_long (
    .clk       (clk),
    .rst       (rst),
    .start     (l_start),
    .abort     (l_abort),
    .golden    (l_golden),
    .dut_in    (l_dut_in),
    .dut_out   (l_dut_out),
    .busy      (l_busy),
    .done      (l_done),
    .pass      (l_pass),
    .signature (l_sig)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run; returns in the idle cycle after done, so a following call is
  // a back-to-back start.
  task automatic run_bist(input int mode_i, input logic [7:0] gold, input logic [31:0] exp_mid,
                          input logic [7:0] exp_sig, input logic exp_pass, input bit noisy,
                          input string tag);
    int n;
    bit got_done;
    logic [7:0] mid;
    mode   = mode_i;
    golden = gold;
    start  = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    got_done = 1'b0;
    while (n < 60 && !got_done) begin
      if (n % 3 == 0 && n < 12) begin
        check({tag, "_pattern"}, 32'(dut_in), 32'd1 << (n / 3));
      end
      if (n % 3 == 0 && n > 0 && n <= 12) begin
        mid = exp_mid[8*(4-n/3) +: 8];
        check({tag, "_misr_step"}, 32'(signature), 32'(mid));
      end
      start = noisy && (n == 4 || n == 7);
      if (done) begin
        got_done = 1'b1;
        check({tag, "_done_cycle"}, 32'(n + 1), 32'd13);
      end else begin
        tick();
        n++;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end
    tick();
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    check({tag, "_signature"}, 32'(signature), 32'(exp_sig));
    check({tag, "_idle_pattern"}, 32'(dut_in), 32'h10);
  endtask

  typedef struct {
    int          mode;
    logic [7:0]  gold;
    logic [31:0] mid;
    logic [7:0]  sig;
    logic        pass;
    bit          noisy;
    bit          b2b;
    string       tag;
  } vec_t;

  // Hand-computed MISR steps for patterns 01,02,04,08 with mask 0x1D.
  vec_t vecs [6];

  initial begin
    int n;
    int ndone;
    int dup;
    int done_cyc;
    bit seen [16384];

    vecs[0] = '{0, 8'h00, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 1'b0, "zero"};
    vecs[1] = '{1, 8'h00, 32'h0100_0400, 8'h00, 1'b1, 1'b0, 1'b0, "ident_pass"};
    vecs[2] = '{1, 8'h0F, 32'h0100_0400, 8'h00, 1'b0, 1'b0, 1'b0, "ident_fail"};
    vecs[3] = '{2, 8'h6C, 32'hFE1C_C36C, 8'h6C, 1'b1, 1'b1, 1'b0, "inv_noisy"};
    vecs[4] = '{2, 8'h6C, 32'hFE1C_C36C, 8'h6C, 1'b1, 1'b0, 1'b1, "inv_b2b"};
    vecs[5] = '{2, 8'h6D, 32'hFE1C_C36C, 8'h6C, 1'b0, 1'b0, 1'b0, "inv_fail"};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_dut_in", 32'(dut_in), 32'h0001);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_signature", 32'(signature), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b) tick();
      run_bist(vecs[i].mode, vecs[i].gold, vecs[i].mid, vecs[i].sig, vecs[i].pass,
               vecs[i].noisy, vecs[i].tag);
    end

    // Abort in the second settle cycle of the second pattern.
    tick();
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_dut_in_frozen", 32'(dut_in), 32'h0002);
    check("abort_misr_frozen", 32'(signature), 32'hFE);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("abort_stays_idle", 32'(ndone), 32'd0);
    // start together with abort in idle: start wins, run restarts from seed.
    abort = 1'b1;
    run_bist(2, 8'h6C, 32'hFE1C_C36C, 8'h6C, 1'b1, 1'b0, "rerun");

    // Asynchronous reset between edges during the second capture.
    tick();
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("prerst_misr", 32'(signature), 32'hFE);
    #2 rst = 1'b1;
    #1;
    check("arst_dut_in", 32'(dut_in), 32'h0001);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_pass", 32'(pass), 32'd0);
    check("arst_signature", 32'(signature), 32'd0);
    #1 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("arst_stays_idle", 32'(ndone), 32'd0);

    // Full-period run: every nonzero 14-bit state exactly once.
    for (int i = 0; i < 16384; i++) seen[i] = 1'b0;
    l_golden = 8'h00;
    l_start = 1'b1;
    tick();
    l_start = 1'b0;
    n = 0;
    dup = 0;
    done_cyc = 0;
    while (n < 50000 && done_cyc == 0) begin
      if (n % 3 == 0 && n / 3 < 16383) begin
        if (l_dut_in == 14'h0 || seen[l_dut_in]) dup++;
        seen[l_dut_in] = 1'b1;
      end
      if (l_done) begin
        done_cyc = n + 1;
      end else begin
        tick();
        n++;
      end
    end
    check("long_unique_nonzero", 32'(dup), 32'd0);
    check("long_done_cycle", 32'(done_cyc), 32'd49150);
    tick();
    check("long_pass", 32'(l_pass), 32'd1);
    check("long_signature", 32'(l_sig), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
